dvi_frame_formatter: RTL and testbench

// Pixel-stream to DVI frame formatter; sits directly upstream of the three tmds_encoder_dvi channels.

---
 rtl/dvi_frame_formatter.sv | 149 ++++++++++++++
 tb/tb_dvi_frame_formatter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dvi_frame_formatter.sv
// DVI frame formatter: free-running 2D timing generator that locks an AXI4-Stream
// RGB888 source to frame boundaries and drives colour/control/DE to the TMDS encoders.
module dvi_frame_formatter #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [23:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue,
  output logic [1:0]  o_ctrl_b,
  output logic        o_de,
  output logic        o_frame_start,
  output logic        o_underflow,
  output logic        o_misalign
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_EOL      = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic HS_ON = 1'(H_POL);
  localparam logic VS_ON = 1'(V_POL);

  typedef enum logic [1:0] {SEEK, WAIT, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic [23:0]     pix_q, pix_d;
  logic [1:0]      ctrl_q, ctrl_d;
  logic            de_q, de_d;
  logic            frame_start_q, frame_start_d;
  logic            underflow_q, underflow_d;
  logic            misalign_q, misalign_d;

  logic line_end, frame_end, active, hs_on, vs_on, sof_pos, eol_pos;

  always_comb begin
    line_end  = (h_cnt_q == H_LAST);
    frame_end = line_end && (v_cnt_q == V_LAST);
    active    = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    hs_on     = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
    vs_on     = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);
    sof_pos   = (h_cnt_q == '0) && (v_cnt_q == '0);
    eol_pos   = (h_cnt_q == H_EOL);

    h_cnt_d = line_end ? '0 : h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (line_end) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);

    ctrl_d        = {vs_on ? VS_ON : ~VS_ON, hs_on ? HS_ON : ~HS_ON};
    de_d          = active;
    frame_start_d = sof_pos;

    state_d       = state_q;
    pix_d         = 24'h000000;
    underflow_d   = 1'b0;
    misalign_d    = 1'b0;
    s_axis_tready = 1'b0;

    // The SOF beat is held back in SEEK so LOCKED can consume it at (0,0).
    case (state_q)
      SEEK: begin
        s_axis_tready = !(s_axis_tvalid && s_axis_tuser);
        if (s_axis_tvalid && s_axis_tuser) state_d = WAIT;
      end
      WAIT: begin
        if (frame_end) state_d = LOCKED;
      end
      LOCKED: begin
        s_axis_tready = active;
        if (active) begin
          if (!s_axis_tvalid) begin
            underflow_d = 1'b1;
            state_d     = SEEK;
          end else begin
            pix_d = s_axis_tdata;
            if ((s_axis_tuser != sof_pos) || (s_axis_tlast != eol_pos)) begin
              misalign_d = 1'b1;
              state_d    = SEEK;
            end
          end
        end
      end
      default: state_d = SEEK;
    endcase

    if (i_rst) s_axis_tready = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= SEEK;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pix_q         <= 24'h000000;
      ctrl_q        <= {~VS_ON, ~HS_ON};
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pix_q         <= pix_d;
      ctrl_q        <= ctrl_d;
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
      misalign_q    <= misalign_d;
    end
  end

  assign o_red         = pix_q[23:16];
  assign o_green       = pix_q[15:8];
  assign o_blue        = pix_q[7:0];
  assign o_ctrl_b      = ctrl_q;
  assign o_de          = de_q;
  assign o_frame_start = frame_start_q;
  assign o_underflow   = underflow_q;
  assign o_misalign    = misalign_q;

endmodule

// File: tb/tb_dvi_frame_formatter.sv
// Directed bench for dvi_frame_formatter on a 14x7 raster; a second instance with
// inverted sync polarity shares the stimulus and is checked on every step.
module tb_dvi_frame_formatter;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] tData;
  logic        tValid, tUser, tLast;

  logic        readyA, deA, fsA, ufA, maA;
  logic [7:0]  redA, greenA, blueA;
  logic [1:0]  ctrlA;
  logic        readyB, deB, fsB, ufB, maB;
  logic [7:0]  redB, greenB, blueB;
  logic [1:0]  ctrlB;

  int compared   = 0;
  int mismatched = 0;
  int hPos = 0;
  int vPos = 0;
  int deCount = 0;
  int srcP = 0;

  always #5 clock = ~clock;

  dvi_frame_formatter #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(0), .V_POL(0)
  ) dutA (
    .i_clk(clock), .i_rst(reset),
    .s_axis_tdata(tData), .s_axis_tvalid(tValid), .s_axis_tready(readyA),
    .s_axis_tuser(tUser), .s_axis_tlast(tLast),
    .o_red(redA), .o_green(greenA), .o_blue(blueA), .o_ctrl_b(ctrlA),
    .o_de(deA), .o_frame_start(fsA), .o_underflow(ufA), .o_misalign(maA)
  );

  dvi_frame_formatter #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1), .V_POL(1)
  ) dutB (
    .i_clk(clock), .i_rst(reset),
    .s_axis_tdata(tData), .s_axis_tvalid(tValid), .s_axis_tready(readyB),
    .s_axis_tuser(tUser), .s_axis_tlast(tLast),
    .o_red(redB), .o_green(greenB), .o_blue(blueB), .o_ctrl_b(ctrlB),
    .o_de(deB), .o_frame_start(fsB), .o_underflow(ufB), .o_misalign(maB)
  );

  function automatic logic [23:0] pix(input int h, input int v);
    return 24'(h + 16 * v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s at h=%0d v=%0d: observed=%0h expected=%0h", tag, hPos, vPos, obs, exp);
    end
  endtask

  // Drive one clock of stimulus, check tready mid-cycle, then move past the edge.
  task automatic applyStimulus(input logic v, input logic [23:0] d, input logic u,
                               input logic l, input logic rst, input logic expRdy);
    tValid = v; tData = d; tUser = u; tLast = l; reset = rst;
    #1;
    chk("tready", 32'(readyA), 32'(expRdy));
    chk("tready_pol1", 32'(readyB), 32'(expRdy));
    @(posedge clock);
    #1;
  endtask

  // Outputs now reflect counter position (h,v) from the previous clock.
  task automatic checkOutput(input int h, input int v, input logic [23:0] expCol,
                             input logic expUf, input logic expMa, input logic inReset);
    logic expDe, expHs, expVs, expFs;
    expDe = !inReset && (h < 8) && (v < 4);
    expHs = inReset ? 1'b1 : !((h >= 10) && (h < 12));
    expVs = inReset ? 1'b1 : !(v == 5);
    expFs = !inReset && (h == 0) && (v == 0);
    if (deA === 1'b1) deCount++;
    chk("de", 32'(deA), 32'(expDe));
    chk("colour", {8'h00, redA, greenA, blueA}, {8'h00, expCol});
    chk("ctrl_b", 32'(ctrlA), 32'({expVs, expHs}));
    chk("frame_start", 32'(fsA), 32'(expFs));
    chk("underflow", 32'(ufA), 32'(expUf));
    chk("misalign", 32'(maA), 32'(expMa));
    chk("ctrl_b_pol1", 32'(ctrlB), 32'({~expVs, ~expHs}));
    chk("de_pol1", 32'(deB), 32'(expDe));
    chk("colour_pol1", {8'h00, redB, greenB, blueB}, {8'h00, expCol});
    chk("fs_uf_ma_pol1", 32'({fsB, ufB, maB}), 32'({expFs, expUf, expMa}));
  endtask

  task automatic step(input logic v, input logic [23:0] d, input logic u, input logic l,
                      input logic expRdy, input logic [23:0] expCol,
                      input logic expUf, input logic expMa);
    applyStimulus(v, d, u, l, 1'b0, expRdy);
    checkOutput(hPos, vPos, expCol, expUf, expMa, 1'b0);
    hPos++;
    if (hPos == 14) begin
      hPos = 0;
      vPos = (vPos == 6) ? 0 : vPos + 1;
    end
  endtask

  // Ramp source while locked: one beat consumed per active clock.
  task automatic lockedSteps(input int n);
    logic act;
    for (int k = 0; k < n; k++) begin
      act = (hPos < 8) && (vPos < 4);
      step(1'b1, pix(srcP % 8, srcP / 8), srcP == 0, (srcP % 8) == 7,
           act, act ? pix(hPos, vPos) : 24'h0, 1'b0, 1'b0);
      if (act) srcP = (srcP + 1) % 32;
    end
  endtask

  // Ramp source while unlocked: beats drain until the SOF beat, then held.
  task automatic drainSteps(input int n);
    logic gotSof;
    logic rdy;
    gotSof = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (srcP == 0) gotSof = 1'b1;
      rdy = !gotSof;
      step(1'b1, pix(srcP % 8, srcP / 8), srcP == 0, (srcP % 8) == 7,
           rdy, 24'h0, 1'b0, 1'b0);
      if (rdy) srcP = (srcP + 1) % 32;
    end
  endtask

  initial begin
    tValid = 1'b0; tData = 24'h0; tUser = 1'b0; tLast = 1'b0; reset = 1'b1;

    // Power-up reset
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput(0, 0, 24'h0, 1'b0, 1'b0, 1'b1);
    hPos = 0; vPos = 0;

    // Idle stream: SEEK with tready high, timing only
    deCount = 0;
    for (int k = 0; k < 98; k++) step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
    chk("idle_de_count", 32'(deCount), 32'd32);

    // SOF presented during SEEK: held unconsumed through WAIT
    for (int k = 0; k < 98; k++) step(1'b1, 24'h0, 1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    srcP = 0;
    lockedSteps(98);

    // Stall at (3,1): underflow, drain to SOF, relock next frame
    lockedSteps(17);
    step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 24'h0, 1'b1, 1'b0);
    drainSteps(80);
    lockedSteps(98);

    // Early tlast at (5,0): pixel still shown, misalign, garbage drained
    lockedSteps(5);
    step(1'b1, pix(5, 0), 1'b0, 1'b1, 1'b1, pix(5, 0), 1'b0, 1'b1);
    srcP = 6;
    step(1'b1, 24'hDEAD01, 1'b0, 1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
    step(1'b1, 24'hDEAD02, 1'b0, 1'b1, 1'b1, 24'h0, 1'b0, 1'b0);
    step(1'b1, 24'hDEAD03, 1'b0, 1'b0, 1'b1, 24'h0, 1'b0, 1'b0);
    drainSteps(89);

    // Relocked frame, then reset at (6,2)
    lockedSteps(34);
    applyStimulus(1'b1, pix(srcP % 8, srcP / 8), 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput(6, 2, 24'h0, 1'b0, 1'b0, 1'b1);
    hPos = 0; vPos = 0;
    drainSteps(98);
    lockedSteps(14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
